dsp_macc_drain: RTL and testbench



---
 rtl/dsp_macc_drain.sv | 126 ++++++++++++
 tb/tb_dsp_macc_drain.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/dsp_macc_drain.sv
// dsp_macc_drain: per-frame sums from a free-running MAC accumulator; DSP_MACC_DRAIN_SAT_EN enables saturation and sat_flag
module dsp_macc_drain #(
    parameter int P_W         = 40,
    parameter int OUT_W       = 18,
    parameter int SHIFT       = 0,
    parameter int MAC_LATENCY = 2,
    parameter int FIFO_DEPTH  = 2
) (
    input  logic             CLK,
    input  logic             SRST,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    input  logic [P_W-1:0]   P,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      frame_cnt
`ifdef DSP_MACC_DRAIN_SAT_EN
    ,
    output logic             sat_flag
`endif
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [P_W:0] RND = ((P_W + 1)'(1) << SHIFT) >> 1;
`ifdef DSP_MACC_DRAIN_SAT_EN
    localparam logic signed [P_W:0] SMAX = $signed({{(P_W - OUT_W + 2){1'b0}}, {(OUT_W - 1){1'b1}}});
    localparam logic signed [P_W:0] SMIN = ~SMAX;
`endif

    typedef enum logic {PRIME, RUN} state_t;

    state_t                 state_q, state_d;
    logic [2:0]             prime_q, prime_d;
    logic [P_W-1:0]         base_q, base_d;
    logic [MAC_LATENCY-1:0] dv_q, dv_d, dl_q, dl_d;
    logic [CNT_W-1:0]       inflight_q, inflight_d, count_q, count_d;
    logic [PTR_W-1:0]       rd_q, rd_d, wr_q, wr_d;
    logic [OUT_W-1:0]       mem_q [FIFO_DEPTH];
    logic [15:0]            frame_q, frame_d;
    logic                   acc, retire, pop;
    logic [P_W-1:0]         diff;
    logic [P_W:0]           rsum;
    logic [OUT_W-1:0]       res;
`ifdef DSP_MACC_DRAIN_SAT_EN
    logic                   sat_q, sat_d, ovf;
    logic signed [P_W:0]    r;
`endif

    function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
        return p == PTR_W'(FIFO_DEPTH - 1) ? '0 : p + PTR_W'(1);
    endfunction

    // credit check, delay-line alignment with P, frame sum, rounding/narrowing and FIFO bookkeeping
    always_comb begin
        in_ready   = state_q == RUN &&
                     ((CNT_W + 1)'(inflight_q) + (CNT_W + 1)'(count_q) < (CNT_W + 1)'(FIFO_DEPTH));
        acc        = in_valid & in_ready;
        retire     = dv_q[MAC_LATENCY-1] & dl_q[MAC_LATENCY-1];
        out_valid  = count_q != '0;
        out_data   = mem_q[rd_q];
        frame_cnt  = frame_q;
        pop        = out_valid & out_ready;
        diff       = P - base_q;
        rsum       = {diff[P_W-1], diff} + RND;
`ifdef DSP_MACC_DRAIN_SAT_EN
        r          = $signed(rsum) >>> SHIFT;
        ovf        = r > SMAX || r < SMIN;
        res        = ovf ? (r[P_W] ? SMIN[OUT_W-1:0] : SMAX[OUT_W-1:0]) : r[OUT_W-1:0];
        sat_d      = sat_q | (retire & ovf);
        sat_flag   = sat_q;
`else
        res        = OUT_W'($signed(rsum) >>> SHIFT);
`endif
        state_d    = state_q;
        prime_d    = state_q == PRIME ? prime_q + 3'd1 : prime_q;
        base_d     = retire ? P : base_q;
        if (state_q == PRIME && prime_q == 3'(MAC_LATENCY)) begin
            state_d = RUN;
            base_d  = P;
        end
        dv_d       = MAC_LATENCY'({dv_q, acc});
        dl_d       = MAC_LATENCY'({dl_q, in_last});
        inflight_d = inflight_q + CNT_W'(acc & in_last) - CNT_W'(retire);
        count_d    = count_q + CNT_W'(retire) - CNT_W'(pop);
        rd_d       = pop ? nxt(rd_q) : rd_q;
        wr_d       = retire ? nxt(wr_q) : wr_q;
        frame_d    = frame_q + 16'(retire);
    end

    // state registers; reset discards in-flight frames and buffered results and re-primes
    always_ff @(posedge CLK) begin
        if (SRST) begin
            state_q    <= PRIME;
            prime_q    <= '0;
            base_q     <= '0;
            dv_q       <= '0;
            dl_q       <= '0;
            inflight_q <= '0;
            count_q    <= '0;
            rd_q       <= '0;
            wr_q       <= '0;
            frame_q    <= '0;
`ifdef DSP_MACC_DRAIN_SAT_EN
            sat_q      <= 1'b0;
`endif
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            prime_q    <= prime_d;
            base_q     <= base_d;
            dv_q       <= dv_d;
            dl_q       <= dl_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            frame_q    <= frame_d;
`ifdef DSP_MACC_DRAIN_SAT_EN
            sat_q      <= sat_d;
`endif
            if (retire) mem_q[wr_q] <= res;
        end
    end
endmodule

// File: tb/tb_dsp_macc_drain.sv
// tb_dsp_macc_drain: scoreboard bench for dsp_macc_drain driving a behavioural MAC model
`timescale 1ns/1ps
module tb_dsp_macc_drain;
    logic        clk = 1'b0, srst = 1'b1, in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0, ld = 1'b0;
    logic        in_ready, out_valid, s_in_ready, s_out_valid;
    logic [39:0] p_q = '0, stage_q = '0, src_v = '0, ld_val = '0;
    logic [17:0] out_data, s_out_data;
    logic [15:0] frame_cnt, s_frame_cnt;
    logic [17:0] exp_q[$], s_q[$];
    int          checks = 0, failures = 0;
`ifdef DSP_MACC_DRAIN_SAT_EN
    logic        sat_flag, s_sat_flag;
    localparam logic [17:0] OVF_EXP = 18'h1FFFF;
`else
    localparam logic [17:0] OVF_EXP = 18'h00000;
`endif

    dsp_macc_drain u_dut (
        .CLK(clk), .SRST(srst), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .P(p_q), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .frame_cnt(frame_cnt)
`ifdef DSP_MACC_DRAIN_SAT_EN
        , .sat_flag(sat_flag)
`endif
    );

    dsp_macc_drain #(.SHIFT(4)) u_shift (
        .CLK(clk), .SRST(srst), .in_valid(in_valid), .in_last(in_last), .in_ready(s_in_ready),
        .P(p_q), .out_data(s_out_data), .out_valid(s_out_valid), .out_ready(out_ready), .frame_cnt(s_frame_cnt)
`ifdef DSP_MACC_DRAIN_SAT_EN
        , .sat_flag(s_sat_flag)
`endif
    );

    always #5 clk = ~clk;

    // hard-DSP MAC: accepted operand appears on P two edges later; idle beats add zero; never cleared
    always @(posedge clk) begin
        stage_q <= (in_valid && in_ready && s_in_ready) ? src_v : '0;
        p_q     <= ld ? ld_val : p_q + stage_q;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // scoreboard monitor: compare every accepted output against the queued expectation
    always begin
        @(negedge clk);
        #1;
        if (!srst && out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("out_unexpected", {46'd0, out_data}, 64'hDEAD);
            else chk("out_data", {46'd0, out_data}, {46'd0, exp_q.pop_front()});
        end
        if (!srst && s_out_valid && out_ready) begin
            if (s_q.size() == 0) chk("shift_out_unexpected", {46'd0, s_out_data}, 64'hDEAD);
            else chk("shift_out_data", {46'd0, s_out_data}, {46'd0, s_q.pop_front()});
        end
    end

    task automatic expect_out(input logic [17:0] e, input logic [17:0] es);
        exp_q.push_back(e);
        s_q.push_back(es);
    endtask

    task automatic beat(input logic [39:0] v, input logic l);
        int n = 0;
        in_valid = 1'b1;
        in_last  = l;
        src_v    = v;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("beat_timeout", 64'd0, 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        src_v    = '0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || s_q.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 64'(exp_q.size() + s_q.size()), 64'd0);
    endtask

    task automatic do_reset(input logic load, input logic [39:0] v);
        int n = 0;
        srst     = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        ld       = load;
        ld_val   = v;
        exp_q.delete();
        s_q.delete();
        @(negedge clk);
        ld = 1'b0;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_frame_cnt", {48'd0, frame_cnt}, 64'd0);
`ifdef DSP_MACC_DRAIN_SAT_EN
        chk("rst_sat_flag", {63'd0, sat_flag}, 64'd0);
`endif
        @(negedge clk);
        srst = 1'b0;
        chk("rst_out_data", {46'd0, out_data}, 64'd0);
        while (!in_ready && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("prime_cycles", 64'(n), 64'd3);
    endtask

    initial begin
        int w;
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        do_reset(1'b1, 40'h12_3456_7890);
        expect_out(18'd18, 18'd1);
        beat(40'd5, 1'b0);
        beat(40'd6, 1'b0);
        beat(40'd7, 1'b1);
        w = 0;
        while (!out_valid && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("latency", 64'(w), 64'd2);
        out_ready = 1'b1;
        wait_drain();
        chk("frame_cnt_t1", {48'd0, frame_cnt}, 64'd1);
        expect_out(18'h3FFFD, 18'd0);
        beat(40'hFF_FFFF_FFFD, 1'b1);
        expect_out(18'd100, 18'd6);
        beat(40'd40, 1'b0);
        beat(40'd60, 1'b1);
        expect_out(18'd0, 18'd0);
        beat(40'd1, 1'b0);
        beat(40'd2, 1'b0);
        beat(40'd3, 1'b0);
        beat(40'hFF_FFFF_FFFA, 1'b1);
        wait_drain();
        expect_out(18'd24, 18'd2);
        beat(40'd24, 1'b1);
        expect_out(18'h3FFE8, 18'h3FFFF);
        beat(40'hFF_FFFF_FFE2, 1'b0);
        beat(40'd6, 1'b1);
        wait_drain();
        out_ready = 1'b0;
        expect_out(18'd1, 18'd0);
        beat(40'd1, 1'b1);
        expect_out(18'd2, 18'd0);
        beat(40'd2, 1'b1);
        chk("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
        repeat (3) @(negedge clk);
        chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
        chk("bp_head", {46'd0, out_data}, 64'd1);
        @(negedge clk);
        chk("bp_hold", {46'd0, out_data}, 64'd1);
        chk("bp_in_ready_still_low", {63'd0, in_ready}, 64'd0);
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_credit_return", {63'd0, in_ready}, 64'd1);
        expect_out(18'd3, 18'd0);
        beat(40'd3, 1'b1);
        wait_drain();
        chk("frame_cnt_t4", {48'd0, frame_cnt}, 64'd9);
        chk("shift_frame_cnt_t4", {48'd0, s_frame_cnt}, 64'd9);
        do_reset(1'b1, 40'hFF_FFFF_FFF0);
        expect_out(18'd32, 18'd2);
        beat(40'd32, 1'b1);
        wait_drain();
        chk("frame_cnt_wrap", {48'd0, frame_cnt}, 64'd1);
        expect_out(OVF_EXP, 18'd16384);
        beat(40'h00_0004_0000, 1'b1);
        wait_drain();
`ifdef DSP_MACC_DRAIN_SAT_EN
        chk("sat_flag_set", {63'd0, sat_flag}, 64'd1);
        chk("shift_sat_flag_clear", {63'd0, s_sat_flag}, 64'd0);
`endif
        out_ready = 1'b0;
        expect_out(18'd7, 18'd0);
        beat(40'd7, 1'b1);
        w = 0;
        while (!out_valid && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("mid_fifo_loaded", {63'd0, out_valid}, 64'd1);
        expect_out(18'd9, 18'd1);
        beat(40'd9, 1'b1);
        do_reset(1'b0, '0);
        out_ready = 1'b1;
        expect_out(18'd11, 18'd1);
        beat(40'd11, 1'b1);
        wait_drain();
        chk("frame_cnt_after_mid_reset", {48'd0, frame_cnt}, 64'd1);
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
